// File: rtl/esn_pkg.sv
// Shared definitions for the echo state network readout: width helpers and FSM encoding.
package esn_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Unsigned cell times signed weight, summed over all cells, cannot overflow this width.
  function automatic int calc_acc_width(input int dw, input int ww, input int rs);
    return dw + ww + clog2(rs) + 1;
  endfunction

endpackage

// File: rtl/esn_readout_mac.sv
// Signed multiply-accumulate: unsigned cell state times signed weight into a clearable accumulator.
module readout_mac
  import esn_pkg::*;
#(
  parameter int data_width   = 3,
  parameter int weight_width = 4,
  parameter int acc_width    = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en_i,
  input  logic                           clr_i,
  input  logic                           acc_en_i,
  input  logic [data_width-1:0]          cell_i,
  input  logic signed [weight_width-1:0] weight_i,
  output logic signed [acc_width-1:0]    acc_o
);

  localparam int prod_width = data_width + weight_width + 1;

  logic signed [prod_width-1:0] cell_ext;
  logic signed [prod_width-1:0] weight_ext;
  logic signed [prod_width-1:0] product;
  logic signed [acc_width-1:0]  product_ext;
  logic signed [acc_width-1:0]  acc_q, acc_d;

  // The cell is zero-extended so a top bit of 1 is never read as a sign.
  assign cell_ext    = $signed({{(prod_width - data_width){1'b0}}, cell_i});
  assign weight_ext  = {{(prod_width - weight_width){weight_i[weight_width-1]}}, weight_i};
  assign product     = cell_ext * weight_ext;
  assign product_ext = {{(acc_width - prod_width){product[prod_width-1]}}, product};

  // NOTE: combinational blocks assign a default first so no path leaves acc_d unassigned (no latch).
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_q + product_ext;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/esn_readout.sv
// Linear readout of the reservoir: snapshots the cell vector and serially sums cell*weight.
module esn_readout
  import esn_pkg::*;
#(
  parameter  int reservoir_size = 3,
  parameter  int data_width     = 3,
  parameter  int weight_width   = 4,
  localparam int idx_width      = clog2(reservoir_size),
  localparam int acc_width      = calc_acc_width(data_width, weight_width, reservoir_size)
) (
  input  logic                                 iClk,
  input  logic                                 iRst_n,
  input  logic                                 iEn,
  input  logic [data_width*reservoir_size-1:0] iState,
  input  logic                                 iStart,
  input  logic                                 iWeWr,
  input  logic [idx_width-1:0]                 iWeAddr,
  input  logic [weight_width-1:0]              iWeData,
  output logic                                 oBusy,
  output logic [acc_width-1:0]                 oResult,
  output logic                                 oValid
);

  localparam logic [idx_width-1:0] last_idx = idx_width'(reservoir_size - 1);

  state_t                         state_q, state_d;
  logic [idx_width-1:0]           idx_q, idx_d;
  logic [data_width-1:0]          shadow_q [reservoir_size];
  logic signed [weight_width-1:0] weight_q [reservoir_size];
  logic signed [acc_width-1:0]    result_q, result_d;
  logic signed [acc_width-1:0]    acc;
  logic                           valid_q, valid_d;
  logic                           snap, mac_clr, mac_acc, we_ok;

  assign we_ok = iWeWr && (state_q == ST_IDLE) && (32'(iWeAddr) < 32'(reservoir_size));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    result_d = result_q;
    valid_d  = 1'b0;
    snap     = 1'b0;
    mac_clr  = 1'b0;
    mac_acc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          snap    = 1'b1;
          mac_clr = 1'b1;
          idx_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        mac_acc = 1'b1;
        idx_d   = idx_q + 1'b1;
        if (idx_q == last_idx) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        result_d = acc;
        valid_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else if (iEn) begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: the weight file is reset element by element because a reset must leave every weight at zero.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int k = 0; k < reservoir_size; k++) begin
        shadow_q[k] <= '0;
        weight_q[k] <= '0;
      end
    end else if (iEn) begin
      if (snap) begin
        for (int k = 0; k < reservoir_size; k++) begin
          shadow_q[k] <= iState[k*data_width +: data_width];
        end
      end
      if (we_ok) begin
        weight_q[iWeAddr] <= iWeData;
      end
    end
  end

  readout_mac #(
    .data_width  (data_width),
    .weight_width(weight_width),
    .acc_width   (acc_width)
  ) u_mac (
    .clk     (iClk),
    .rst_n   (iRst_n),
    .en_i    (iEn),
    .clr_i   (mac_clr),
    .acc_en_i(mac_acc),
    .cell_i  (shadow_q[idx_q]),
    .weight_i(weight_q[idx_q]),
    .acc_o   (acc)
  );

  assign oBusy   = (state_q != ST_IDLE);
  assign oResult = result_q;
  assign oValid  = valid_q;

endmodule

// File: tb/tb_esn_readout.sv
// Self-checking bench for esn_readout with a queue of expected readout sums.
module tb_esn_readout;

  localparam int RS = 3;
  localparam int DW = 3;
  localparam int WW = 4;
  localparam int AW = 10;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic [RS*DW-1:0]     state_in;
  logic                 start;
  logic                 we_wr;
  logic [1:0]           we_addr;
  logic [WW-1:0]        we_data;
  logic                 busy;
  logic signed [AW-1:0] result;
  logic                 valid;

  int checks = 0;
  int errors = 0;
  int model_w [RS];
  logic signed [AW-1:0] exp_q [$];

  esn_readout #(
    .reservoir_size(RS),
    .data_width    (DW),
    .weight_width  (WW)
  ) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .iEn    (en),
    .iState (state_in),
    .iStart (start),
    .iWeWr  (we_wr),
    .iWeAddr(we_addr),
    .iWeData(we_data),
    .oBusy  (busy),
    .oResult(result),
    .oValid (valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_sum(input int c0, input int c1, input int c2);
    return c0 * model_w[0] + c1 * model_w[1] + c2 * model_w[2];
  endfunction

  task automatic write_weight(input int addr, input int data);
    we_wr   = 1'b1;
    we_addr = 2'(addr);
    we_data = WW'(data);
    step();
    we_wr = 1'b0;
    if (addr < RS) model_w[addr] = data;
  endtask

  task automatic readout(input int c0, input int c1, input int c2,
                         output int lat, output logic signed [AW-1:0] res, output logic busy_t);
    state_in = {DW'(c2), DW'(c1), DW'(c0)};
    start    = 1'b1;
    exp_q.push_back(AW'(model_sum(c0, c1, c2)));
    step();
    start    = 1'b0;
    busy_t   = busy;
    state_in = '1;
    lat      = -1;
    res      = '0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (valid === 1'b1) begin
        lat = k;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b1; start = 1'b0; we_wr = 1'b0;
    we_addr = '0; we_data = '0; state_in = '0;
    for (int k = 0; k < RS; k++) model_w[k] = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++;
    if (result !== '0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result); end
    @(negedge clk) rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_zero_weights();
    int lat; logic signed [AW-1:0] res, exp; logic bt;
    readout(7, 7, 7, lat, res, bt);
    exp = exp_q.pop_front();
    checks++;
    if (res !== exp) begin errors++; $display("FAIL zero_result: got %0d expected %0d", res, exp); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL zero_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_basic();
    int lat; logic signed [AW-1:0] res, exp; logic bt;
    write_weight(0, 1); write_weight(1, 2); write_weight(2, 3);
    readout(7, 0, 5, lat, res, bt);
    exp = exp_q.pop_front();
    checks++;
    if (res !== exp) begin errors++; $display("FAIL basic_result: got %0d expected %0d", res, exp); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    checks++;
    if (bt !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %b expected 1", bt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    step();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got %b expected 0", valid); end
  endtask

  task automatic test_negative();
    int lat; logic signed [AW-1:0] res, exp; logic bt;
    write_weight(0, -8); write_weight(1, -8); write_weight(2, -8);
    readout(7, 7, 7, lat, res, bt);
    exp = exp_q.pop_front();
    checks++;
    if (res !== exp) begin errors++; $display("FAIL neg_result: got %0d expected %0d", res, exp); end
  endtask

  task automatic test_busy();
    int lat, extra; logic signed [AW-1:0] res, exp; logic bt;
    state_in = {DW'(3), DW'(2), DW'(1)};
    start = 1'b1;
    exp_q.push_back(AW'(model_sum(1, 2, 3)));
    step();
    start = 1'b0;
    step();
    start = 1'b1; we_wr = 1'b1; we_addr = 2'd0; we_data = WW'(-1);
    step();
    start = 1'b0; we_wr = 1'b0;
    lat = -1; res = '0;
    for (int k = 3; k <= 20; k++) begin
      step();
      if (valid === 1'b1) begin lat = k; res = result; break; end
    end
    exp = exp_q.pop_front();
    checks++;
    if (res !== exp) begin errors++; $display("FAIL busy_result: got %0d expected %0d", res, exp); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL busy_latency: got %0d expected 4", lat); end
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (valid === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL busy_start_ignored: got %0d active cycles expected 0", extra); end
    readout(1, 0, 0, lat, res, bt);
    exp = exp_q.pop_front();
    checks++;
    if (res !== exp) begin errors++; $display("FAIL busy_old_weight: got %0d expected %0d", res, exp); end
    write_weight(3, 5);
    readout(1, 1, 1, lat, res, bt);
    exp = exp_q.pop_front();
    checks++;
    if (res !== exp) begin errors++; $display("FAIL bad_addr_write: got %0d expected %0d", res, exp); end
  endtask

  task automatic test_back_to_back();
    int seen; int ks [2]; logic signed [AW-1:0] exp;
    write_weight(0, 1); write_weight(1, 2); write_weight(2, 3);
    state_in = {DW'(5), DW'(0), DW'(7)};
    start = 1'b1;
    exp_q.push_back(AW'(model_sum(7, 0, 5)));
    exp_q.push_back(AW'(model_sum(1, 1, 1)));
    step();
    state_in = {DW'(1), DW'(1), DW'(1)};
    seen = 0; ks[0] = -1; ks[1] = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (valid === 1'b1) begin
        exp = exp_q.pop_front();
        checks++;
        if (result !== exp) begin errors++; $display("FAIL b2b_result%0d: got %0d expected %0d", seen, result, exp); end
        ks[seen] = k;
        seen++;
        if (seen == 2) begin start = 1'b0; break; end
      end
    end
    start = 1'b0;
    exp_q.delete();
    checks++;
    if (ks[0] !== 4) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 4", ks[0]); end
    checks++;
    if (ks[1] !== 9) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 9", ks[1]); end
    repeat (2) step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_enable();
    int lat; logic signed [AW-1:0] res, exp;
    state_in = {DW'(5), DW'(0), DW'(7)};
    start = 1'b1;
    exp_q.push_back(AW'(model_sum(7, 0, 5)));
    step();
    start = 1'b0;
    step();
    en = 1'b0;
    step(); step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL en_frozen_busy: got %b expected 1", busy); end
    en = 1'b1;
    lat = -1; res = '0;
    for (int k = 4; k <= 24; k++) begin
      step();
      if (valid === 1'b1) begin lat = k; res = result; break; end
    end
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL en_latency: got %0d expected 6", lat); end
    checks++;
    if (res !== exp) begin errors++; $display("FAIL en_result: got %0d expected %0d", res, exp); end
    en = 1'b0;
    step(); step();
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL en_valid_held: got %b expected 1", valid); end
    checks++;
    if (result !== exp) begin errors++; $display("FAIL en_result_held: got %0d expected %0d", result, exp); end
    en = 1'b1;
    step();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL en_valid_clear: got %b expected 0", valid); end
  endtask

  task automatic test_reset_mid();
    int lat, extra; logic signed [AW-1:0] res, exp; logic bt;
    write_weight(0, 1); write_weight(1, 2); write_weight(2, 3);
    state_in = {DW'(7), DW'(7), DW'(7)};
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", valid); end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < RS; k++) model_w[k] = 0;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (valid === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL rstmid_no_valid: got %0d valid cycles expected 0", extra); end
    readout(7, 7, 7, lat, res, bt);
    exp = exp_q.pop_front();
    checks++;
    if (res !== exp) begin errors++; $display("FAIL rstmid_weights_cleared: got %0d expected %0d", res, exp); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL rstmid_latency: got %0d expected 4", lat); end
  endtask

  initial begin
    test_reset();
    test_zero_weights();
    test_basic();
    test_negative();
    test_busy();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
